// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the mips32 memory bus arbiter: state encoding,
// byte-lane width and the common register-word constants.
package mem_bus_arbiter_pkg;

   localparam int REG_W = 32;
   typedef logic [REG_W-1:0] reg_bus_t;
   localparam reg_bus_t ZERO_WORD = '0;

   localparam int SEL_W = 4;
   typedef logic [SEL_W-1:0] sel_bus_t;
   localparam sel_bus_t ALL_LANES = 4'b1111;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUS_MEM = 2'b01,
      BUS_IF  = 2'b10,
      SETTLE  = 2'b11
   } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Wishbone-style shared bus between the arbiter (master) and the memory
// slave. stb always mirrors cyc on this bus.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import mem_bus_arbiter_pkg::*;

   logic              cyc;
   logic              stb;
   logic              we;
   sel_bus_t          sel;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (
      output cyc, stb, we, sel, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  cyc, stb, we, sel, addr, wdata,
      output rdata, ack
   );

endinterface

// File: rtl/mem_bus_arbiter_arb_watchdog.sv
// Bus-cycle watchdog for the memory arbiter: counts un-acked cycles of the
// current bus access and flags expiry on the last allowed cycle. Only
// instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt;

   // Cycle counter: cleared when a bus access is launched, advances while waiting.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst || start) begin
         cnt <= '0;
      end else if (active && !ack) begin
         cnt <= cnt + 8'd1;
      end
   end

   // A same-cycle ack wins over expiry.
   assign expired = active && !ack && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority (MEM over IF) arbiter sharing one Wishbone-style bus
// between the fetch and data-memory stages of the mips32 pipeline.
// Optional bus watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  sel_bus_t          mem_sel_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_ack_o,
   mem_bus_arbiter_if.master bus,
   output logic              stallreq_o,
   output logic              timeout_err_o
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
   end

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic              in_bus;
   logic              launch;
   logic              expire;
   logic              done;
   logic              we_q;
   sel_bus_t          sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign launch = (state == IDLE) && (mem_req_i || if_req_i);
   assign done   = bus.ack || expire;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: MEM wins ties; SETTLE masks a not-yet-dropped request.
   always_comb begin
      // NOTE: default first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_req_i) begin
               state_nxt = BUS_MEM;
            end else if (if_req_i) begin
               state_nxt = BUS_IF;
            end
         end
         BUS_MEM, BUS_IF: begin
            if (done) begin
               state_nxt = SETTLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: bus cycle flags follow the state, stall is purely combinational.
   always_comb begin
      in_bus     = (state == BUS_MEM) || (state == BUS_IF);
      bus.cyc    = in_bus;
      bus.stb    = in_bus;
      stallreq_o = (if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o);
   end

   // Bus request registers, read-data capture and one-cycle ack pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q        <= 1'b0;
         sel_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
         if_ack_o    <= 1'b0;
         mem_ack_o   <= 1'b0;
      end else begin
         if_ack_o  <= 1'b0;
         mem_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  we_q    <= mem_we_i;
                  sel_q   <= mem_sel_i;
                  addr_q  <= mem_addr_i;
                  wdata_q <= mem_wdata_i;
               end else if (if_req_i) begin
                  we_q   <= 1'b0;
                  sel_q  <= ALL_LANES;
                  addr_q <= if_addr_i;
               end
            end
            BUS_MEM: begin
               if (done) begin
                  we_q        <= 1'b0;
                  mem_rdata_o <= bus.ack ? bus.rdata : '0;
                  mem_ack_o   <= 1'b1;
               end
            end
            BUS_IF: begin
               if (done) begin
                  we_q       <= 1'b0;
                  if_rdata_o <= bus.ack ? bus.rdata : '0;
                  if_ack_o   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.we    = we_q;
   assign bus.sel   = sel_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
   logic err_q;

   arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .start  (launch),
      .active (in_bus),
      .ack    (bus.ack),
      .expired(expire)
   );

   // Error pulse aligned with the ack issued for an expired access.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= expire;
      end
   end

   assign timeout_err_o = err_q;
`else
   assign expire        = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stallreq;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_rdata_o   (if_rdata),
      .if_ack_o     (if_ack),
      .mem_req_i    (mem_req),
      .mem_we_i     (mem_we),
      .mem_sel_i    (mem_sel),
      .mem_addr_i   (mem_addr),
      .mem_wdata_i  (mem_wdata),
      .mem_rdata_o  (mem_rdata),
      .mem_ack_o    (mem_ack),
      .bus          (bus),
      .stallreq_o   (stallreq),
      .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      sample();
      n_cmp++;
      if ({bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, bus.wdata} !== 71'h0) begin
         n_bad++;
         $display("FAIL reset_bus: got %h want 0", {bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, bus.wdata});
      end
      n_cmp++;
      if ({if_ack, mem_ack, timeout_err, stallreq} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 0000", {if_ack, mem_ack, timeout_err, stallreq});
      end
      n_cmp++;
      if ({if_rdata, mem_rdata} !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h want 0", {if_rdata, mem_rdata});
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_lone_fetch();
      step();                                    // cycle 0
      if_req = 1'b1; if_addr = 32'h0000_0040;
      sample();
      n_cmp++;
      if ({stallreq, bus.cyc} !== 2'b10) begin
         n_bad++;
         $display("FAIL fetch_c0 stall/cyc: got %b want 10", {stallreq, bus.cyc});
      end
      for (int c = 1; c <= 2; c++) begin         // cycles 1-2
         step();
         if (c == 2) begin bus.ack = 1'b1; bus.rdata = 32'h3C01_0001; end
         sample();
         n_cmp++;
         if ({bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, stallreq, if_ack} !== {3'b110, 4'hF, 32'h40, 2'b10}) begin
            n_bad++;
            $display("FAIL fetch_bus_c%0d: got %h want %h", c,
                     {bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, stallreq, if_ack}, {3'b110, 4'hF, 32'h40, 2'b10});
         end
      end
      step();                                    // cycle 3 (SETTLE)
      bus.ack = 1'b0; bus.rdata = 32'hFFFF_FFFF;
      sample();
      n_cmp++;
      if ({if_ack, if_rdata, mem_ack, bus.cyc, stallreq} !== {1'b1, 32'h3C01_0001, 3'b000}) begin
         n_bad++;
         $display("FAIL fetch_ack: got %h want %h", {if_ack, if_rdata, mem_ack, bus.cyc, stallreq}, {1'b1, 32'h3C01_0001, 3'b000});
      end
      step();                                    // cycle 4
      if_req = 1'b0;
      sample();
      n_cmp++;
      if ({if_ack, bus.cyc} !== 2'b00) begin
         n_bad++;
         $display("FAIL fetch_after: got %b want 00", {if_ack, bus.cyc});
      end
      step();
      sample();
      n_cmp++;
      if (bus.cyc !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_no_reissue: got %b want 0", bus.cyc);
      end
   endtask

   task automatic test_simultaneous();
      step();                                    // cycle 0
      if_req = 1'b1; if_addr = 32'h0000_0200;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0100; mem_wdata = '0;
      sample();
      step();                                    // cycle 1: MEM on bus, 1-cycle slave
      bus.ack = 1'b1; bus.rdata = 32'h1111_2222;
      sample();
      n_cmp++;
      if ({bus.cyc, bus.we, bus.addr} !== {2'b10, 32'h100}) begin
         n_bad++;
         $display("FAIL simul_mem_first: got %h want %h", {bus.cyc, bus.we, bus.addr}, {2'b10, 32'h100});
      end
      step();                                    // cycle 2: SETTLE for MEM
      bus.ack = 1'b0; bus.rdata = 32'hFFFF_FFFF;
      sample();
      n_cmp++;
      if ({mem_ack, mem_rdata, if_ack, if_rdata, bus.cyc, stallreq} !== {1'b1, 32'h1111_2222, 1'b0, 32'h3C01_0001, 2'b01}) begin
         n_bad++;
         $display("FAIL simul_mem_ack: got %h want %h", {mem_ack, mem_rdata, if_ack, if_rdata, bus.cyc, stallreq},
                  {1'b1, 32'h1111_2222, 1'b0, 32'h3C01_0001, 2'b01});
      end
      step();                                    // cycle 3: IDLE, IF granted now
      mem_req = 1'b0;
      sample();
      n_cmp++;
      if ({bus.cyc, if_ack} !== 2'b00) begin
         n_bad++;
         $display("FAIL simul_idle_gap: got %b want 00", {bus.cyc, if_ack});
      end
      step();                                    // cycle 4: IF on bus
      bus.ack = 1'b1; bus.rdata = 32'h3333_4444;
      sample();
      n_cmp++;
      if ({bus.cyc, bus.we, bus.sel, bus.addr} !== {2'b10, 4'hF, 32'h200}) begin
         n_bad++;
         $display("FAIL simul_if_bus: got %h want %h", {bus.cyc, bus.we, bus.sel, bus.addr}, {2'b10, 4'hF, 32'h200});
      end
      step();                                    // cycle 5: SETTLE for IF
      bus.ack = 1'b0;
      sample();
      n_cmp++;
      if ({if_ack, if_rdata, mem_ack, mem_rdata} !== {1'b1, 32'h3333_4444, 1'b0, 32'h1111_2222}) begin
         n_bad++;
         $display("FAIL simul_if_ack: got %h want %h", {if_ack, if_rdata, mem_ack, mem_rdata},
                  {1'b1, 32'h3333_4444, 1'b0, 32'h1111_2222});
      end
      step();
      if_req = 1'b0;
      sample();
      n_cmp++;
      if ({stallreq, bus.cyc} !== 2'b00) begin
         n_bad++;
         $display("FAIL simul_done: got %b want 00", {stallreq, bus.cyc});
      end
   endtask

   task automatic test_store();
      step();                                    // cycle 0
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
      mem_addr = 32'h0000_0080; mem_wdata = 32'hDEAD_BEEF;
      sample();
      for (int c = 1; c <= 3; c++) begin         // slave acks in cycle 3
         step();
         if (c == 3) begin bus.ack = 1'b1; bus.rdata = 32'h0; end
         sample();
         n_cmp++;
         if ({bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, bus.wdata, mem_ack} !==
             {3'b111, 4'h3, 32'h80, 32'hDEAD_BEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL store_bus_c%0d: got %h want %h", c,
                     {bus.cyc, bus.stb, bus.we, bus.sel, bus.addr, bus.wdata, mem_ack},
                     {3'b111, 4'h3, 32'h80, 32'hDEAD_BEEF, 1'b0});
         end
      end
      step();                                    // cycle 4: SETTLE
      bus.ack = 1'b0;
      sample();
      n_cmp++;
      if ({mem_ack, bus.cyc, bus.we} !== 3'b100) begin
         n_bad++;
         $display("FAIL store_ack: got %b want 100", {mem_ack, bus.cyc, bus.we});
      end
      step();                                    // cycle 5
      mem_req = 1'b0; mem_we = 1'b0;
      sample();
      n_cmp++;
      if (mem_ack !== 1'b0) begin
         n_bad++;
         $display("FAIL store_ack_width: got %b want 0", mem_ack);
      end
   endtask

   task automatic test_no_double_issue();
      int   starts = 0;
      int   acks   = 0;
      logic prev   = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 0) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0140;
         end
         bus.ack   = (c == 1);
         bus.rdata = 32'h0000_0055;
         if (c == 3) mem_req = 1'b0;             // requester reacts one cycle after its ack
         sample();
         if (bus.cyc && !prev) starts++;
         prev = bus.cyc;
         if (mem_ack) acks++;
      end
      bus.ack = 1'b0;
      n_cmp++;
      if (starts !== 1) begin
         n_bad++;
         $display("FAIL double_issue_cycles: got %0d want 1", starts);
      end
      n_cmp++;
      if (acks !== 1) begin
         n_bad++;
         $display("FAIL double_issue_acks: got %0d want 1", acks);
      end
   endtask

   task automatic test_reset_mid();
      step();                                    // cycle 0
      if_req = 1'b1; if_addr = 32'h0000_0300;
      sample();
      step();                                    // cycle 1
      sample();
      n_cmp++;
      if ({bus.cyc, bus.addr} !== {1'b1, 32'h300}) begin
         n_bad++;
         $display("FAIL rstmid_bus: got %h want %h", {bus.cyc, bus.addr}, {1'b1, 32'h300});
      end
      step();                                    // cycle 2: reset asserted, no ack
      rst = 1'b1;
      sample();
      n_cmp++;
      if (bus.cyc !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_sync: got %b want 1", bus.cyc);
      end
      step();                                    // cycle 3: after the reset edge
      rst = 1'b0; if_req = 1'b0;
      sample();
      n_cmp++;
      if ({bus.cyc, bus.stb, if_ack, mem_ack, bus.addr} !== 36'h0) begin
         n_bad++;
         $display("FAIL rstmid_abandon: got %h want 0", {bus.cyc, bus.stb, if_ack, mem_ack, bus.addr});
      end
      for (int c = 4; c <= 6; c++) begin
         step();
         bus.ack = (c == 4);                     // stray late slave ack
         sample();
         n_cmp++;
         if ({bus.cyc, if_ack, mem_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid_no_ack_c%0d: got %b want 000", c, {bus.cyc, if_ack, mem_ack});
         end
      end
      bus.ack = 1'b0;
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      step();                                    // cycle 0
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0400;
      bus.ack = 1'b0; bus.rdata = 32'hAAAA_AAAA;
      sample();
      for (int c = 1; c <= 4; c++) begin         // four un-acked bus cycles
         step();
         sample();
         n_cmp++;
         if ({bus.cyc, mem_ack, timeout_err} !== 3'b100) begin
            n_bad++;
            $display("FAIL timeout_wait_c%0d: got %b want 100", c, {bus.cyc, mem_ack, timeout_err});
         end
      end
      step();                                    // cycle 5
      sample();
      n_cmp++;
      if ({bus.cyc, mem_ack, mem_rdata, timeout_err} !== {2'b01, 32'h0, 1'b1}) begin
         n_bad++;
         $display("FAIL timeout_expire: got %h want %h", {bus.cyc, mem_ack, mem_rdata, timeout_err}, {2'b01, 32'h0, 1'b1});
      end
      step();
      mem_req = 1'b0;
      sample();
      n_cmp++;
      if ({mem_ack, timeout_err} !== 2'b00) begin
         n_bad++;
         $display("FAIL timeout_pulse: got %b want 00", {mem_ack, timeout_err});
      end
   endtask
`else
   task automatic test_no_timeout();
      step();                                    // cycle 0
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0400;
      bus.ack = 1'b0; bus.rdata = 32'hAAAA_AAAA;
      sample();
      for (int c = 1; c <= 8; c++) begin         // waits well past TIMEOUT_CYCLES
         step();
         if (c == 8) bus.ack = 1'b1;
         sample();
         n_cmp++;
         if ({bus.cyc, mem_ack, timeout_err} !== 3'b100) begin
            n_bad++;
            $display("FAIL notimeout_wait_c%0d: got %b want 100", c, {bus.cyc, mem_ack, timeout_err});
         end
      end
      step();                                    // cycle 9
      bus.ack = 1'b0;
      sample();
      n_cmp++;
      if ({mem_ack, mem_rdata, timeout_err} !== {1'b1, 32'hAAAA_AAAA, 1'b0}) begin
         n_bad++;
         $display("FAIL notimeout_ack: got %h want %h", {mem_ack, mem_rdata, timeout_err}, {1'b1, 32'hAAAA_AAAA, 1'b0});
      end
      step();
      mem_req = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      bus.ack = 1'b0; bus.rdata = '0;

      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_store();
      test_no_double_issue();
      test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
